// File: rtl/playback_sequencer.sv
// Plays a recorded key sequence from the recording RAM, one cell per step.
// Each cell is fetched, latched onto keys_out and held for a fixed number of ticks.
module playback_sequencer #(
  parameter int NUM_CELLS      = 29,
  parameter int ADDR_W         = 5,
  parameter int KEY_W          = 4,
  parameter int TICKS_PER_CELL = 50000000,
  parameter int TICK_W         = 26
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] length,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [KEY_W-1:0]  rd_data,
  output logic [KEY_W-1:0]  keys_out,
  output logic              playing,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, HOLD, DONE} state_t;

  // len is one bit wider so NUM_CELLS == 2**ADDR_W still fits.
  localparam logic [ADDR_W:0]   MAX_LEN   = (ADDR_W+1)'(NUM_CELLS);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICKS_PER_CELL - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cell_reg, cell_next;
  logic [ADDR_W:0]   len_reg, len_next;
  logic [TICK_W-1:0] cnt_reg, cnt_next;
  logic [KEY_W-1:0]  keys_reg, keys_next;

  logic [ADDR_W:0]   length_clamped;
  logic              last_cell;

  assign length_clamped = ({1'b0, length} > MAX_LEN) ? MAX_LEN : {1'b0, length};
  assign last_cell      = ({1'b0, cell_reg} == (len_reg - (ADDR_W+1)'(1)));
  assign keys_out       = keys_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= IDLE;
      cell_reg  <= '0;
      len_reg   <= '0;
      cnt_reg   <= '0;
      keys_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cell_reg  <= cell_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
      keys_reg  <= keys_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cell_next  = cell_reg;
    len_next   = len_reg;
    cnt_next   = cnt_reg;
    keys_next  = keys_reg;
    rd_en      = 1'b0;
    rd_addr    = cell_reg;
    playing    = 1'b0;
    done       = 1'b0;

    case (state_reg)
      IDLE: begin
        rd_addr = '0;
        if (start && !stop) begin
          len_next   = length_clamped;
          cell_next  = '0;
          state_next = (length_clamped == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        rd_en      = 1'b1;
        playing    = 1'b1;
        state_next = LOAD;
      end
      LOAD: begin
        playing    = 1'b1;
        keys_next  = rd_data;
        cnt_next   = '0;
        state_next = HOLD;
      end
      HOLD: begin
        playing  = 1'b1;
        cnt_next = cnt_reg + TICK_W'(1);
        if (cnt_reg == LAST_TICK) begin
          if (last_cell && !loop_en) begin
            state_next = DONE;
          end else begin
            cell_next  = last_cell ? '0 : cell_reg + ADDR_W'(1);
            state_next = FETCH;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        keys_next  = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Abort wins over everything; any read already issued is simply never latched.
    if (state_reg != IDLE && stop) begin
      state_next = IDLE;
      keys_next  = '0;
    end
  end

endmodule

// File: tb/tb_playback_sequencer.sv
// Randomized bench for playback_sequencer; expected outputs come from a
// per-cycle timing model derived from the playback schedule.
module tb_playback_sequencer;
  localparam int NUM_CELLS = 8;
  localparam int ADDR_W    = 5;
  localparam int KEY_W     = 4;
  localparam int TICKS     = 4;
  localparam int TICK_W    = 3;
  localparam int P         = TICKS + 2;
  localparam int VW        = ADDR_W + KEY_W + 3;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop_en = 1'b0;
  logic [ADDR_W-1:0] length = '0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [KEY_W-1:0]  rd_data = '0;
  logic [KEY_W-1:0]  keys_out;
  logic              playing;
  logic              done;

  logic [KEY_W-1:0]  mem [0:(1<<ADDR_W)-1];
  logic [VW-1:0]     obs;
  logic [VW-1:0]     exp_v;
  int total = 0;
  int bad = 0;

  playback_sequencer #(
    .NUM_CELLS(NUM_CELLS), .ADDR_W(ADDR_W), .KEY_W(KEY_W),
    .TICKS_PER_CELL(TICKS), .TICK_W(TICK_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .loop_en(loop_en), .length(length), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .keys_out(keys_out), .playing(playing), .done(done)
  );

  always #5 clock = ~clock;

  // One-cycle-latency RAM
  always @(posedge clock) if (rd_en) rd_data <= mem[rd_addr];

  assign obs = {rd_en, rd_addr, keys_out, playing, done};

  // Expected {rd_en, rd_addr, keys_out, playing, done} at cycle t+d for a
  // playback of C cell slots over L cells, start accepted at cycle t.
  function automatic logic [VW-1:0] model(input int d, input int L, input int C);
    int last, s;
    logic e, pl, dn;
    logic [ADDR_W-1:0] a;
    logic [KEY_W-1:0] k;
    last = (L == 0) ? 1 : 1 + C * P;
    e = 1'b0; pl = 1'b0; a = '0; k = '0;
    dn = (d == last);
    if (L > 0) begin
      if (d >= 1 && d < last) begin
        pl = 1'b1;
        e = ((d - 1) % P == 0);
      end
      if (d >= 1 && d <= last) begin
        s = (d - 1) / P;
        if (s > C - 1) s = C - 1;
        a = ADDR_W'(s % L);
      end
      if (d >= 3 && d <= last) begin
        s = (d - 3) / P;
        if (s > C - 1) s = C - 1;
        k = mem[s % L];
      end
    end
    return {e, a, k, pl, dn};
  endfunction

  task automatic fill_mem(input bit counting);
    for (int i = 0; i < (1 << ADDR_W); i++)
      mem[i] = counting ? KEY_W'(i + 1) : KEY_W'($urandom);
  endtask

  task automatic start_play(input int len_in, input bit lp);
    @(posedge clock); #1;
    length = ADDR_W'(len_in);
    loop_en = lp;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    length = ADDR_W'($urandom);
  endtask

  task automatic test_reset;
    start = 1'b1;
    length = ADDR_W'(3);
    for (int d = 0; d < 3; d++) begin
      @(negedge clock);
      total++;
      if (obs !== '0) begin
        bad++;
        $display("FAIL reset d=%0d got=%h exp=%h", d, obs, {VW{1'b0}});
      end
    end
    @(posedge clock); #1;
    start = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_basic;
    int len_in, L, last;
    for (int it = 0; it < 5; it++) begin
      fill_mem(it == 0);
      len_in = (it == 0) ? 3 : $urandom_range(1, 31);
      L = (len_in > NUM_CELLS) ? NUM_CELLS : len_in;
      last = 1 + L * P;
      start_play(len_in, 1'b0);
      for (int d = 1; d <= last + 3; d++) begin
        @(negedge clock);
        exp_v = model(d, L, L);
        total++;
        if (obs !== exp_v) begin
          bad++;
          $display("FAIL basic it=%0d len=%0d d=%0d got=%h exp=%h", it, len_in, d, obs, exp_v);
        end
        // Start pulses mid-playback must be ignored
        start = (it > 0 && d < last) ? 1'($urandom) : 1'b0;
      end
      start = 1'b0;
    end
  endtask

  task automatic test_loop;
    int L, C, last;
    for (int it = 0; it < 4; it++) begin
      fill_mem(it == 0);
      L = (it == 0) ? 2 : $urandom_range(1, NUM_CELLS);
      C = (it == 0) ? 4 : L * $urandom_range(1, 3);
      last = 1 + C * P;
      start_play(L, 1'b1);
      for (int d = 1; d <= last + 3; d++) begin
        @(negedge clock);
        exp_v = model(d, L, C);
        total++;
        if (obs !== exp_v) begin
          bad++;
          $display("FAIL loop it=%0d L=%0d C=%0d d=%0d got=%h exp=%h", it, L, C, d, obs, exp_v);
        end
        // Drop loop_en inside the final slot's hold, before its decision point
        if (d == 3 + (C - 1) * P) loop_en = 1'b0;
      end
    end
  endtask

  task automatic test_stop;
    int L, last, ab;
    for (int it = 0; it < 6; it++) begin
      fill_mem(it < 2);
      L = (it < 2) ? 3 : $urandom_range(1, NUM_CELLS);
      last = 1 + L * P;
      // it 0: stop mid-hold of cell 1; it 1: uninterrupted replay from cell 0
      ab = (it == 0) ? 3 + P + 1 : (it == 1) ? last + 10 : $urandom_range(1, last - 1);
      start_play(L, 1'b0);
      for (int d = 1; d <= last + 3; d++) begin
        @(negedge clock);
        exp_v = (d > ab) ? '0 : model(d, L, L);
        total++;
        if (obs !== exp_v) begin
          bad++;
          $display("FAIL stop it=%0d L=%0d at=%0d d=%0d got=%h exp=%h", it, L, ab, d, obs, exp_v);
        end
        stop = (d == ab);
      end
      stop = 1'b0;
    end
  endtask

  task automatic test_boundaries;
    fill_mem(1'b0);
    start_play(0, 1'b0);
    for (int d = 1; d <= 5; d++) begin
      @(negedge clock);
      exp_v = model(d, 0, 0);
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL len_zero d=%0d got=%h exp=%h", d, obs, exp_v);
      end
    end
    start_play(31, 1'b0);
    for (int d = 1; d <= 1 + NUM_CELLS * P + 3; d++) begin
      @(negedge clock);
      exp_v = model(d, NUM_CELLS, NUM_CELLS);
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL len_clamp d=%0d got=%h exp=%h", d, obs, exp_v);
      end
    end
    @(posedge clock); #1;
    start = 1'b1;
    stop = 1'b1;
    length = ADDR_W'($urandom_range(1, 31));
    @(posedge clock); #1;
    start = 1'b0;
    stop = 1'b0;
    for (int d = 1; d <= 10; d++) begin
      @(negedge clock);
      total++;
      if (obs !== '0) begin
        bad++;
        $display("FAIL start_stop d=%0d got=%h exp=%h", d, obs, {VW{1'b0}});
      end
    end
  endtask

  task automatic test_reset_load;
    int L, last, ab;
    for (int it = 0; it < 4; it++) begin
      fill_mem(1'b0);
      L = $urandom_range(2, NUM_CELLS);
      last = 1 + L * P;
      // Even iterations: reset during LOAD; odd: a clean run after recovery
      ab = (it % 2 == 0) ? 2 : last + 10;
      start_play(L, 1'b0);
      for (int d = 1; d <= last + 3; d++) begin
        @(negedge clock);
        exp_v = (d > ab) ? '0 : model(d, L, L);
        total++;
        if (obs !== exp_v) begin
          bad++;
          $display("FAIL reset_load it=%0d L=%0d d=%0d got=%h exp=%h", it, L, d, obs, exp_v);
        end
        reset = (d == ab) ? 1'b0 : 1'b1;
      end
      reset = 1'b1;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_loop;
    test_stop;
    test_boundaries;
    test_reset_load;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
